// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the shared memory port and mem_arbiter.
//   slave  : view taken by mem_arbiter (requests and mem_rdata in; responses and memory
//            strobes out).
//   master : view taken by the environment (requesters plus memory model).
// Signals:
//   i_req/i_addr, i_rdata/i_done/i_stall           fetch side
//   d_req/d_wr/d_addr/d_wdata, d_rdata/d_done/d_stall data side
//   mem_en/mem_wr/mem_addr/mem_wdata, mem_rdata     shared memory port
interface mem_arbiter_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic [15:0] i_rdata;
  logic        i_done;
  logic        i_stall;

  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        d_stall;

  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
           mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for one shared multi-cycle memory port serving instruction fetch (I)
// and data load/store (D). One transaction at a time: IDLE grants, BUSY holds the port for
// LATENCY cycles, RESP pulses the owner's done for one cycle.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   bus   : mem_arbiter_if.slave (requests, responses, stalls, memory port)
// Parameter:
//   LATENCY : memory access cycles per transaction, 1..15
// Build option:
//   MEM_ARB_FAIR_EN : when defined, a last-grant bit makes simultaneous requests alternate
//                     between sides; otherwise D always beats I.
module mem_arbiter #(
  parameter int unsigned LATENCY = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  localparam logic       OwnerI  = 1'b0;
  localparam logic       OwnerD  = 1'b1;
  localparam logic [3:0] CntInit = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic [15:0] i_rdata_q, i_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;

  logic grant;
  logic grant_d_side;

`ifdef MEM_ARB_FAIR_EN
  logic last_q, last_d;
`endif

  assign grant = (state_q == StIdle) && (bus.i_req || bus.d_req);

  // Winner selection; only matters when both sides request together.
  always_comb begin
`ifdef MEM_ARB_FAIR_EN
    if (bus.i_req && bus.d_req) begin
      grant_d_side = (last_q == OwnerI);
    end else begin
      grant_d_side = bus.d_req;
    end
`else
    grant_d_side = bus.d_req;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant) state_d = StBusy;
      StBusy:  if (cnt_q == 4'd0) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Transaction latch, countdown and read-data capture
  always_comb begin
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
`ifdef MEM_ARB_FAIR_EN
    last_d    = last_q;
`endif
    if (grant) begin
      owner_d = grant_d_side ? OwnerD : OwnerI;
      addr_d  = grant_d_side ? bus.d_addr : bus.i_addr;
      wr_d    = grant_d_side & bus.d_wr;
      wdata_d = bus.d_wdata;
      cnt_d   = CntInit;
`ifdef MEM_ARB_FAIR_EN
      last_d  = grant_d_side ? OwnerD : OwnerI;
`endif
    end else if (state_q == StBusy) begin
      if (cnt_q == 4'd0) begin
        // Last BUSY cycle: mem_rdata is valid now. Stores leave d_rdata alone.
        if (owner_q == OwnerI) begin
          i_rdata_d = bus.mem_rdata;
        end else if (!wr_q) begin
          d_rdata_d = bus.mem_rdata;
        end
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 4'd0;
      owner_q   <= OwnerI;
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      wr_q      <= 1'b0;
      i_rdata_q <= 16'h0000;
      d_rdata_q <= 16'h0000;
`ifdef MEM_ARB_FAIR_EN
      last_q    <= OwnerD;
`endif
    end else begin
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef MEM_ARB_FAIR_EN
      last_q    <= last_d;
`endif
    end
  end

  // Outputs; memory strobes derive from state so reset drops them at the same edge.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.i_done    = 1'b0;
    bus.d_done    = 1'b0;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.i_rdata   = i_rdata_q;
    bus.d_rdata   = d_rdata_q;
    unique case (state_q)
      StBusy: begin
        bus.mem_en = 1'b1;
        bus.mem_wr = (owner_q == OwnerD) && wr_q;
      end
      StResp: begin
        bus.i_done = (owner_q == OwnerI);
        bus.d_done = (owner_q == OwnerD);
      end
      default: ;
    endcase
    bus.i_stall = bus.i_req & ~bus.i_done;
    bus.d_stall = bus.d_req & ~bus.d_done;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int unsigned L = 4;

  typedef struct {
    bit          side;      // 1 = data, 0 = fetch
    logic [15:0] addr;
    bit          wr;
    logic [15:0] wdata;
    logic [15:0] rdata;     // owner's rdata expected at done
    int          done_cyc;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  int   en_cnt = 0;

  txn_t        exp_q[$];
  logic [15:0] refmem[logic [15:0]];
  logic [15:0] tbmem[logic [15:0]];
  bit          m_last_d = 1'b1;
  logic [15:0] m_i_rdata = 16'h0000;
  logic [15:0] m_d_rdata = 16'h0000;

  mem_arbiter_if bus();

  mem_arbiter #(.LATENCY(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] dflt(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3C3;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    if (refmem.exists(a)) return refmem[a];
    return dflt(a);
  endfunction

  function automatic logic [15:0] tb_rd(input logic [15:0] a);
    if (tbmem.exists(a)) return tbmem[a];
    return dflt(a);
  endfunction

  // Memory: stores land while strobed; read data is tagged with the cycle number so a
  // capture in the wrong cycle shows up as a data error.
  initial begin
    bus.mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (bus.mem_en && bus.mem_wr) tbmem[bus.mem_addr] = bus.mem_wdata;
      bus.mem_rdata = tb_rd(bus.mem_addr) ^ cyc[15:0];
    end
  end

  // Monitor: checks bus activity and completions against the head of the expected queue.
  initial begin
    txn_t h;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("i_stall", bus.i_stall, bus.i_req & ~bus.i_done);
        chk("d_stall", bus.d_stall, bus.d_req & ~bus.d_done);
        if (bus.mem_en) begin
          chk("txn_pending_on_mem_en", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            h = exp_q[0];
            chk("mem_addr", bus.mem_addr, h.addr);
            chk("mem_wr", bus.mem_wr, h.wr);
            if (h.wr) chk("mem_wdata", bus.mem_wdata, h.wdata);
            en_cnt++;
          end
        end
        if (bus.i_done || bus.d_done) begin
          chk("txn_pending_on_done", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            h = exp_q.pop_front();
            chk("i_done_side", bus.i_done, !h.side);
            chk("d_done_side", bus.d_done, h.side);
            chk("done_cycle", cyc, h.done_cyc);
            chk("busy_cycles", en_cnt, L);
            chk(h.side ? "d_rdata" : "i_rdata", h.side ? bus.d_rdata : bus.i_rdata, h.rdata);
          end
          en_cnt = 0;
        end
      end
    end
  end

  // One round: requests rise together at the current cycle; the model decides service
  // order and predicts each completion. Called at posedge+1 with the arbiter idle.
  task automatic run_round(input bit use_i, input bit use_d, input logic [15:0] ia,
                           input logic [15:0] da, input bit dwr, input logic [15:0] dwd);
    int   c0, g_i, g_d, dn_i, dn_d, last_cyc;
    bit   d_first;
    txn_t t;
    c0 = cyc;
    if (use_i && use_d) begin
`ifdef MEM_ARB_FAIR_EN
      d_first = !m_last_d;
`else
      d_first = 1'b1;
`endif
    end else begin
      d_first = use_d;
    end
    g_i = c0;
    g_d = c0;
    if (use_i && use_d) begin
      if (d_first) g_i = c0 + L + 2;
      else g_d = c0 + L + 2;
    end
    dn_i = g_i + L + 1;
    dn_d = g_d + L + 1;
    last_cyc = (use_i && use_d) ? c0 + 2 * L + 3 : c0 + L + 1;
    for (int k = 0; k < 2; k++) begin
      bit side;
      side = (k == 0) ? d_first : !d_first;
      if ((side && use_d) || (!side && use_i)) begin
        t.side = side;
        if (side) begin
          t.addr = da;
          t.wr = dwr;
          t.wdata = dwd;
          if (dwr) refmem[da] = dwd;
          else m_d_rdata = ref_rd(da) ^ 16'(g_d + L);
          t.rdata = m_d_rdata;
          t.done_cyc = dn_d;
        end else begin
          t.addr = ia;
          t.wr = 1'b0;
          t.wdata = 16'h0000;
          m_i_rdata = ref_rd(ia) ^ 16'(g_i + L);
          t.rdata = m_i_rdata;
          t.done_cyc = dn_i;
        end
        m_last_d = side;
        exp_q.push_back(t);
      end
    end
    while (cyc <= last_cyc) begin
      bus.i_req = use_i && (cyc <= dn_i);
      bus.d_req = use_d && (cyc <= dn_d);
      // After its grant a side's inputs are scrambled; only latched values may reach memory.
      bus.i_addr = (cyc <= g_i) ? ia : 16'($urandom);
      if (cyc <= g_d) begin
        bus.d_addr = da;
        bus.d_wr = dwr;
        bus.d_wdata = dwd;
      end else begin
        bus.d_addr = 16'($urandom);
        bus.d_wr = 1'($urandom);
        bus.d_wdata = 16'($urandom);
      end
      @(posedge clk);
      #1;
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
  endtask

  initial begin
    int pat;
    rst = 1'b1;
    bus.i_req = 1'b0;
    bus.i_addr = 16'h0000;
    bus.d_req = 1'b0;
    bus.d_wr = 1'b0;
    bus.d_addr = 16'h0000;
    bus.d_wdata = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_i_rdata", bus.i_rdata, 16'h0000);
    chk("rst_d_rdata", bus.d_rdata, 16'h0000);
    chk("rst_i_done", bus.i_done, 0);
    chk("rst_d_done", bus.d_done, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_wr", bus.mem_wr, 0);
    chk("rst_mem_addr", bus.mem_addr, 16'h0000);
    chk("rst_mem_wdata", bus.mem_wdata, 16'h0000);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    run_round(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000);
    run_round(1'b0, 1'b1, 16'h0000, 16'h0100, 1'b1, 16'hBEEF);
    run_round(1'b0, 1'b1, 16'h0000, 16'h0100, 1'b0, 16'h0000);
    run_round(1'b1, 1'b1, 16'h0010, 16'h0100, 1'b0, 16'h0000);
    // Back-to-back contested rounds exercise the fairness rule (or fixed priority).
    repeat (3) run_round(1'b1, 1'b1, 16'h0020, 16'h0004, 1'b0, 16'h0000);

    repeat (60) begin
      pat = $urandom_range(1, 3);
      run_round(pat[0], pat[1], 16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)),
                1'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (2) @(posedge clk);
    #1;
    chk("txns_outstanding", exp_q.size(), 0);
    mon_en = 1'b0;

    // Abort a load with reset in its second BUSY cycle.
    bus.d_req = 1'b1;
    bus.d_wr = 1'b0;
    bus.d_addr = 16'h0005;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("abort_mem_en_before", bus.mem_en, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.d_req = 1'b0;
    chk("abort_mem_en", bus.mem_en, 0);
    chk("abort_mem_wr", bus.mem_wr, 0);
    chk("abort_d_done", bus.d_done, 0);
    chk("abort_d_rdata", bus.d_rdata, 16'h0000);
    repeat (L + 2) begin
      @(posedge clk);
      #1;
      chk("abort_no_d_done", bus.d_done, 0);
      chk("abort_idle_mem_en", bus.mem_en, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
